// File: rtl/hamming_pkg.sv
// hamming_pkg: shared constants, position maps and FSM states for the SECDED(16,11) receive path.
package hamming_pkg;
    localparam int NBITS = 16;
    localparam int DBITS = 11;
    localparam int PAR_POS [4] = '{1, 2, 4, 8};
    localparam int DATA_POS [DBITS] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef enum logic [1:0] {IDLE, SHIFT, DECODE, HOLD} state_t;

    // Syndrome bit j is the parity of every position whose index has PAR_POS[j] set,
    // i.e. the XOR of the indices of all set positions.
    function automatic logic [3:0] syndrome(input logic [NBITS-1:0] cw);
        logic [3:0] s;
        s = '0;
        for (int j = 0; j < 4; j++)
            for (int i = 1; i < NBITS; i++)
                if ((i & PAR_POS[j]) != 0) s[j] = s[j] ^ cw[i];
        return s;
    endfunction
endpackage

// File: rtl/hamming_secded_dec.sv
// hamming_secded_dec: combinational SECDED(16,11) decode of one assembled codeword.
module hamming_secded_dec
    import hamming_pkg::*;
(
    input  logic [NBITS-1:0] cw,
    output logic [3:0]       syn,
    output logic             par,
    output logic [DBITS-1:0] data,
    output logic             single_err,
    output logic             double_err
);
    logic [NBITS-1:0] fix;

    assign syn        = syndrome(cw);
    assign par        = ^cw;
    assign fix        = cw ^ (NBITS'(par) << syn);
    assign single_err = par;
    assign double_err = !par && (syn != 4'd0);

    for (genvar i = 0; i < DBITS; i++) begin : g_data
        assign data[i] = fix[DATA_POS[i]];
    end
endmodule

// File: rtl/hamming_rx_deser.sv
// hamming_rx_deser: assembles serial SECDED(16,11) codewords, decodes them and
// presents corrected data with error status on a valid/ready handshake.
module hamming_rx_deser
    import hamming_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [DBITS-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             single_err,
    output logic             double_err,
    output logic [3:0]       err_pos,
    output logic             overrun,
    output logic             resync
);
    state_t           state;
    logic [3:0]       cnt;
    logic [NBITS-1:0] sr;
    logic [3:0]       dec_syn;
    logic             dec_par;
    logic [DBITS-1:0] dec_data;
    logic             dec_single;
    logic             dec_double;

    hamming_secded_dec u_dec (
        .cw        (sr),
        .syn       (dec_syn),
        .par       (dec_par),
        .data      (dec_data),
        .single_err(dec_single),
        .double_err(dec_double)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            single_err <= 1'b0;
            double_err <= 1'b0;
            err_pos    <= '0;
            overrun    <= 1'b0;
            resync     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            resync  <= 1'b0;
            case (state)
                IDLE: begin
                    if (din_valid && sof) begin
                        sr    <= {{(NBITS-1){1'b0}}, din};
                        cnt   <= 4'd1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (din_valid && sof) begin
                        sr     <= {{(NBITS-1){1'b0}}, din};
                        cnt    <= 4'd1;
                        resync <= 1'b1;
                    end else if (din_valid) begin
                        sr[cnt] <= din;
                        cnt     <= cnt + 4'd1;
                        if (cnt == 4'd15) state <= DECODE;
                    end
                end
                DECODE: begin
                    dout       <= dec_data;
                    single_err <= dec_single;
                    double_err <= dec_double;
                    err_pos    <= dec_par ? dec_syn : 4'd0;
                    overrun    <= din_valid && sof;
                    state      <= HOLD;
                end
                HOLD: begin
                    // Results were latched in DECODE; valid rises one edge later.
                    overrun <= din_valid && sof;
                    if (!dout_valid) dout_valid <= 1'b1;
                    else if (dout_ready) begin
                        dout_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
